scan_la_driver: RTL and testbench

- Register-driven sequencer that generates the logic-analyser scan-chain drive signals (clock, data, select, latch enable) consumed by the scan controller in LA mode (driver_sel = 01).
- Caravel firmware supplies a design index and an input byte, then pulses start.
- The block shifts the byte to the selected design, latches it, loads all design outputs, shifts the whole chain back and returns the selected design's output byte, with programmable bit timing.

---
 rtl/scan_la_driver_pkg.sv | 38 +++
 rtl/scan_phase_timer.sv | 27 ++
 rtl/scan_la_driver.sv | 209 ++++++++++++++++++++
 tb/tb_scan_la_driver.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_la_driver_pkg.sv
// Shared constants and state encoding for the logic-analyser scan-chain driver.
package scan_pkg;

    // Default chain geometry.
    localparam int unsigned NUM_DESIGNS_DEF = 8;
    localparam int unsigned NUM_IOS_DEF     = 8;

    // Width of the design index / design counter (covers 0..NUM_DESIGNS).
    localparam int unsigned DSN_CNT_W = 9;

    // State encodings, in sequence order.
    localparam logic [3:0] ENC_IDLE        = 4'd0;
    localparam logic [3:0] ENC_IN_LO       = 4'd1;
    localparam logic [3:0] ENC_IN_HI       = 4'd2;
    localparam logic [3:0] ENC_LATCH_SETUP = 4'd3;
    localparam logic [3:0] ENC_LATCH       = 4'd4;
    localparam logic [3:0] ENC_LOAD_SETUP  = 4'd5;
    localparam logic [3:0] ENC_LOAD_HI     = 4'd6;
    localparam logic [3:0] ENC_LOAD_HOLD   = 4'd7;
    localparam logic [3:0] ENC_OUT_LO      = 4'd8;
    localparam logic [3:0] ENC_OUT_HI      = 4'd9;
    localparam logic [3:0] ENC_DONE        = 4'd10;

    typedef enum logic [3:0] {
        StIdle       = ENC_IDLE,
        StInLo       = ENC_IN_LO,
        StInHi       = ENC_IN_HI,
        StLatchSetup = ENC_LATCH_SETUP,
        StLatch      = ENC_LATCH,
        StLoadSetup  = ENC_LOAD_SETUP,
        StLoadHi     = ENC_LOAD_HI,
        StLoadHold   = ENC_LOAD_HOLD,
        StOutLo      = ENC_OUT_LO,
        StOutHi      = ENC_OUT_HI,
        StDone       = ENC_DONE
    } scan_state_e;

endpackage

// File: rtl/scan_phase_timer.sv
// Phase timer: counts 0..half_period, expire flags the last cycle of a phase.
module scan_phase_timer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] half_period,
    output logic             expire
);

    logic [DIV_W-1:0] count_q;

    // Counter restarts at 0 whenever the owner clears it (state entry / idle).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = (count_q == half_period);

endmodule

// File: rtl/scan_la_driver.sv
// Sequencer producing scan-chain drive signals for logic-analyser mode:
// shift a byte into one design, latch, load outputs, shift the chain back.
module scan_la_driver
    import scan_pkg::*;
#(
    parameter int unsigned NUM_DESIGNS = NUM_DESIGNS_DEF,
    parameter int unsigned NUM_IOS     = NUM_IOS_DEF,
    parameter int unsigned DIV_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DSN_CNT_W-1:0] design_sel,
    input  logic [NUM_IOS-1:0]   data_in,
    input  logic [DIV_W-1:0]     half_period,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [NUM_IOS-1:0]   data_out,
    output logic                 la_scan_clk,
    output logic                 la_scan_data,
    output logic                 la_scan_select,
    output logic                 la_scan_latch_en,
    input  logic                 la_scan_data_ret
);

    localparam int unsigned BIT_W = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
    localparam int unsigned SUM_W = DSN_CNT_W + 1;

    scan_state_e           state_q;
    logic [DSN_CNT_W-1:0]  sel_q;
    logic [DIV_W-1:0]      h_q;
    logic [NUM_IOS-1:0]    in_sr_q;
    logic [NUM_IOS-1:0]    cap_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DSN_CNT_W-1:0]  dsn_q;
    logic                  err_q;

    logic expire;
    logic timer_clear;
    logic bit_last;
    logic in_last;
    logic out_last;
    logic target_win;
    logic sel_bad;

    // Decode counter boundaries and the return window of the target design.
    always_comb begin
        timer_clear = (state_q == StIdle) || (state_q == StDone) || expire;
        bit_last    = (bit_q == BIT_W'(NUM_IOS - 1));
        in_last     = bit_last && (dsn_q == sel_q);
        out_last    = bit_last && (dsn_q == DSN_CNT_W'(NUM_DESIGNS - 1));
        // Return samples arrive tail-first: window dsn_q belongs to design N-1-dsn_q.
        target_win  = (({1'b0, dsn_q} + {1'b0, sel_q}) == SUM_W'(NUM_DESIGNS - 1));
        sel_bad     = (design_sel >= DSN_CNT_W'(NUM_DESIGNS));
    end

    scan_phase_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (timer_clear),
        .half_period(h_q),
        .expire     (expire)
    );

    // Main sequencer; chain pins are set on the edge that enters each state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            sel_q            <= '0;
            h_q              <= '0;
            in_sr_q          <= '0;
            cap_q            <= '0;
            bit_q            <= '0;
            dsn_q            <= '0;
            err_q            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            data_out         <= '0;
            la_scan_clk      <= 1'b0;
            la_scan_data     <= 1'b0;
            la_scan_select   <= 1'b0;
            la_scan_latch_en <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sel_q <= design_sel;
                        h_q   <= half_period;
                        bit_q <= '0;
                        dsn_q <= '0;
                        if (sel_bad) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            err_q        <= 1'b0;
                            busy         <= 1'b1;
                            la_scan_clk  <= 1'b0;
                            la_scan_data <= data_in[NUM_IOS-1];
                            // Remaining bits shift out MSB first, zeros follow.
                            in_sr_q      <= data_in << 1;
                            state_q      <= StInLo;
                        end
                    end
                end
                StInLo: begin
                    if (expire) begin
                        la_scan_clk <= 1'b1;
                        state_q     <= StInHi;
                    end
                end
                StInHi: begin
                    if (expire) begin
                        la_scan_clk <= 1'b0;
                        if (in_last) begin
                            la_scan_data <= 1'b0;
                            bit_q        <= '0;
                            dsn_q        <= '0;
                            state_q      <= StLatchSetup;
                        end else begin
                            la_scan_data <= in_sr_q[NUM_IOS-1];
                            in_sr_q      <= in_sr_q << 1;
                            if (bit_last) begin
                                bit_q <= '0;
                                dsn_q <= dsn_q + 1'b1;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                            state_q <= StInLo;
                        end
                    end
                end
                StLatchSetup: begin
                    if (expire) begin
                        la_scan_latch_en <= 1'b1;
                        state_q          <= StLatch;
                    end
                end
                StLatch: begin
                    if (expire) begin
                        la_scan_latch_en <= 1'b0;
                        la_scan_select   <= 1'b1;
                        state_q          <= StLoadSetup;
                    end
                end
                StLoadSetup: begin
                    if (expire) begin
                        la_scan_clk <= 1'b1;
                        state_q     <= StLoadHi;
                    end
                end
                StLoadHi: begin
                    if (expire) begin
                        la_scan_clk <= 1'b0;
                        state_q     <= StLoadHold;
                    end
                end
                StLoadHold: begin
                    if (expire) begin
                        la_scan_select <= 1'b0;
                        state_q        <= StOutLo;
                    end
                end
                StOutLo: begin
                    if (expire) begin
                        // Sample before the rising edge moves the chain.
                        if (target_win) begin
                            cap_q <= {cap_q[NUM_IOS-2:0], la_scan_data_ret};
                        end
                        la_scan_clk <= 1'b1;
                        state_q     <= StOutHi;
                    end
                end
                StOutHi: begin
                    if (expire) begin
                        la_scan_clk <= 1'b0;
                        if (out_last) begin
                            state_q <= StDone;
                        end else begin
                            if (bit_last) begin
                                bit_q <= '0;
                                dsn_q <= dsn_q + 1'b1;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                            state_q <= StOutLo;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b1;
                    error <= err_q;
                    busy  <= 1'b0;
                    if (!err_q) begin
                        data_out <= cap_q;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_la_driver.sv
// Bench for scan_la_driver: chain model, scoreboard of expected completions,
// and a monitor that checks each done pulse against the queue.
module tb_scan_la_driver;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] design_sel;
    logic [7:0] data_in;
    logic [7:0] half_period;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] data_out;
    logic       la_scan_clk;
    logic       la_scan_data;
    logic       la_scan_select;
    logic       la_scan_latch_en;
    logic       ret_m;

    scan_la_driver dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .design_sel      (design_sel),
        .data_in         (data_in),
        .half_period     (half_period),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .data_out        (data_out),
        .la_scan_clk     (la_scan_clk),
        .la_scan_data    (la_scan_data),
        .la_scan_select  (la_scan_select),
        .la_scan_latch_en(la_scan_latch_en),
        .la_scan_data_ret(ret_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int n_issued = 0;

    typedef struct {
        logic [7:0] dout;
        logic       err;
        int         lat;
        int         start_edge;
    } sb_item_t;
    sb_item_t exp_q[$];
    sb_item_t item;

    // Chain model state.
    logic [63:0] chain = '0;
    logic [7:0]  dout_m [8];
    logic [7:0]  din_m  [8];
    logic        in_bits[$];
    logic        latched = 1'b0;
    int          latch_cyc = 0;
    logic        busy_prev = 1'b0;
    logic        clk_prev = 1'b0;
    logic        latch_prev = 1'b0;
    logic        phase_chk = 1'b0;
    int          t_exp = 1;
    int          hi_run = 0;
    int          lo_run = 0;
    logic        had_hi = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_bits();
        logic [63:0] v = '0;
        for (int i = 0; i < in_bits.size() && i < 64; i++) v = {v[62:0], in_bits[i]};
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Chain model and pin-timing observer, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            in_bits.delete();
            latched   = 1'b0;
            latch_cyc = 0;
            hi_run    = 0;
            lo_run    = 0;
            had_hi    = 1'b0;
        end
        if (la_scan_latch_en) latch_cyc++;
        if (la_scan_latch_en && !latch_prev) begin
            latched = 1'b1;
            for (int d = 0; d < 8; d++) din_m[d] = chain[d*8 +: 8];
        end
        if (la_scan_clk && !clk_prev) begin
            if (la_scan_select) begin
                for (int d = 0; d < 8; d++) chain[d*8 +: 8] = dout_m[d];
            end else begin
                if (!latched) in_bits.push_back(la_scan_data);
                chain = {chain[62:0], la_scan_data};
            end
        end
        ret_m = chain[63];
        if (phase_chk) begin
            if (la_scan_clk) begin
                if (!clk_prev && had_hi)
                    check("clk_lo_len", (lo_run == t_exp) || (lo_run == 2 * t_exp) ||
                          (lo_run == 3 * t_exp), 1'b1);
                hi_run++;
                lo_run = 0;
            end else begin
                if (clk_prev && hi_run != 0) begin
                    check("clk_hi_len", hi_run, t_exp);
                    had_hi = 1'b1;
                end
                hi_run = 0;
                lo_run++;
            end
        end
        busy_prev  = busy;
        clk_prev   = la_scan_clk;
        latch_prev = la_scan_latch_en;
    end

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                item = exp_q.pop_front();
                check("data_out", data_out, item.dout);
                check("error", error, item.err);
                check("latency", cyc - item.start_edge, item.lat);
                check("busy_at_done", busy, 1'b0);
            end
        end
    end

    // Called at a falling edge; start is sampled at the next rising edge.
    task automatic issue(input logic push, input logic [8:0] sel, input logic [7:0] din,
                         input logic [7:0] h, input logic [7:0] exp_dout, input logic exp_err,
                         input int exp_lat);
        design_sel  = sel;
        data_in     = din;
        half_period = h;
        start       = 1'b1;
        if (push) begin
            exp_q.push_back('{dout: exp_dout, err: exp_err, lat: exp_lat, start_edge: cyc + 1});
            n_issued++;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
        end
    endtask

    // id 0 = la_scan_select, id 1 = la_scan_clk.
    task automatic wait_sig(input string name, input int id, input logic lvl);
        int   n = 0;
        logic hit = 1'b0;
        while (!hit && n < 3000) begin
            if (((id == 0) ? la_scan_select : la_scan_clk) == lvl) hit = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no level %0d expected it within 3000 cycles", name, lvl);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        design_sel = '0;
        data_in = '0;
        half_period = '0;
        dout_m[0] = 8'h3C;
        for (int d = 1; d < 8; d++) dout_m[d] = 8'hC0 + 8'(d);
        for (int d = 0; d < 8; d++) din_m[d] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done_err", {done, error}, 2'b00);
        check("rst_data_out", data_out, 8'h00);
        check("rst_la_pins", {la_scan_clk, la_scan_data, la_scan_select, la_scan_latch_en}, 4'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: H=0, sel=0, 0xA5.
        issue(1'b1, 9'd0, 8'hA5, 8'd0, 8'h3C, 1'b0, 150);
        @(negedge clk);
        start = 1'b0;
        check("t1_busy", busy, 1'b1);
        wait_done("t1");
        check("t1_in_count", in_bits.size(), 8);
        check("t1_in_bits", pack_bits(), 64'hA5);
        check("t1_latch_cycles", latch_cyc, 1);
        check("t1_model_din0", din_m[0], 8'hA5);

        // 2: H=3, sel=7, 0xFF; every high phase must be 4 cycles.
        @(negedge clk);
        t_exp = 4;
        phase_chk = 1'b1;
        issue(1'b1, 9'd7, 8'hFF, 8'd3, 8'hC7, 1'b0, 1045);
        @(negedge clk);
        start = 1'b0;
        wait_done("t2");
        phase_chk = 1'b0;
        check("t2_in_count", in_bits.size(), 64);
        check("t2_in_bits", pack_bits(), 64'hFF00_0000_0000_0000);
        check("t2_model_din7", din_m[7], 8'hFF);
        check("t2_latch_cycles", latch_cyc, 4);

        // 3: out-of-range design index.
        @(negedge clk);
        issue(1'b1, 9'd8, 8'h55, 8'd0, 8'hC7, 1'b1, 1);
        @(negedge clk);
        start = 1'b0;
        check("t3_busy", busy, 1'b0);
        check("t3_la_pins_a", {la_scan_clk, la_scan_data, la_scan_select, la_scan_latch_en}, 4'h0);
        wait_done("t3");
        check("t3_la_pins_b", {la_scan_clk, la_scan_data, la_scan_select, la_scan_latch_en}, 4'h0);

        // 4: start while busy is ignored; back-to-back start right after done.
        for (int d = 0; d < 8; d++) dout_m[d] = 8'h10 + 8'(d);
        @(negedge clk);
        issue(1'b1, 9'd1, 8'h5A, 8'd0, 8'h11, 1'b0, 166);
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        issue(1'b0, 9'd4, 8'hFF, 8'd7, 8'h00, 1'b0, 0);
        @(negedge clk);
        start = 1'b0;
        check("t4_busy_after_ignored", busy, 1'b1);
        wait_done("t4a");
        check("t4_model_din1", din_m[1], 8'h5A);
        issue(1'b1, 9'd2, 8'h00, 8'd0, 8'h12, 1'b0, 182);
        @(negedge clk);
        start = 1'b0;
        check("t4_b2b_busy", busy, 1'b1);
        wait_done("t4b");

        // 5: reset during OUT_HI aborts without done.
        @(negedge clk);
        issue(1'b0, 9'd5, 8'h33, 8'd2, 8'h00, 1'b0, 0);
        @(negedge clk);
        start = 1'b0;
        wait_sig("t5_sel_hi", 0, 1'b1);
        wait_sig("t5_sel_lo", 0, 1'b0);
        wait_sig("t5_out_hi", 1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_busy_done_err", {busy, done, error}, 3'b000);
        check("t5_rst_data_out", data_out, 8'h00);
        check("t5_rst_la_pins", {la_scan_clk, la_scan_data, la_scan_select, la_scan_latch_en},
              4'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b1, 9'd5, 8'h77, 8'd2, 8'h15, 1'b0, 688);
        @(negedge clk);
        start = 1'b0;
        wait_done("t5");
        check("t5_model_din5", din_m[5], 8'h77);

        // 6: sel=3 against outputs 0x10..0x17.
        @(negedge clk);
        issue(1'b1, 9'd3, 8'hC3, 8'd1, 8'h13, 1'b0, 395);
        @(negedge clk);
        start = 1'b0;
        wait_done("t6");
        check("t6_model_din3", din_m[3], 8'hC3);

        repeat (5) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("done_count", done_cnt, n_issued);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
